comparator_s1_stage: RTL

- Stage 1 of the two-stage pipelined 16-bit less-than comparator used by the square-root datapath.
- Compares the operand MSB halves and encodes the result as a 2-bit feedback code.
- Registers that code together with the untouched LSB halves and a sideband tag.
- Presents the registered result to the stage-2 comparator through a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered ready_o.

---
 rtl/comparator_s1_stage_if.sv | 40 ++++
 rtl/comparator_s1_stage.sv | 129 ++++++++++++
 2 files changed

// File: rtl/comparator_s1_stage_if.sv
// rtl/comparator_s1_stage_if.sv - handshake/data bundle for comparator stage 1
//
// Purpose: groups the upstream operand handshake and the downstream result
// handshake of comparator_s1_stage into one interface.
// Signal names are taken from the stage's point of view.
//   valid_i, ready_o, A_i, B_i, tag_i          : upstream operand pair
//   valid_o, ready_i, A_lsb_o, B_lsb_o,
//   feedback_o, tag_o                          : downstream result to stage 2
// Modports:
//   slave  : the comparator stage itself
//   master : the environment driving/consuming the stage
interface comparator_s1_stage_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  localparam int HALF = WIDTH / 2;

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic [TAG_W-1:0] tag_i;

  logic             valid_o;
  logic             ready_i;
  logic [HALF-1:0]  A_lsb_o;
  logic [HALF-1:0]  B_lsb_o;
  logic [1:0]       feedback_o;
  logic [TAG_W-1:0] tag_o;

  modport slave (
    input  valid_i, A_i, B_i, tag_i, ready_i,
    output ready_o, valid_o, A_lsb_o, B_lsb_o, feedback_o, tag_o
  );

  modport master (
    output valid_i, A_i, B_i, tag_i, ready_i,
    input  ready_o, valid_o, A_lsb_o, B_lsb_o, feedback_o, tag_o
  );
endinterface

// File: rtl/comparator_s1_stage.sv
// rtl/comparator_s1_stage.sv - stage 1 of the pipelined less-than comparator
//
// Purpose: compares the MSB halves of A and B, encodes the result as a 2-bit
// feedback code (10: A<B, 01: A>B, 00: equal) and registers it together with
// the untouched LSB halves and a sideband tag. A 2-entry skid buffer (output
// register + skid register) allows 1 transfer/cycle with a registered ready_o.
// Ports:
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : comparator_s1_stage_if.slave (upstream and downstream handshakes)
module comparator_s1_stage #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  comparator_s1_stage_if.slave  bus
);
  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q;
  logic             valid_q;
  logic             ready_q;
  logic [HALF-1:0]  a_lsb_q;
  logic [HALF-1:0]  b_lsb_q;
  logic [1:0]       fb_q;
  logic [TAG_W-1:0] tag_q;

  logic [HALF-1:0]  sk_a_lsb_q;
  logic [HALF-1:0]  sk_b_lsb_q;
  logic [1:0]       sk_fb_q;
  logic [TAG_W-1:0] sk_tag_q;

  logic [HALF-1:0]  a_msb;
  logic [HALF-1:0]  b_msb;
  logic [1:0]       fb_d;
  logic             in_xfer;

  assign a_msb   = bus.A_i[WIDTH-1:HALF];
  assign b_msb   = bus.B_i[WIDTH-1:HALF];
  assign in_xfer = bus.valid_i & ready_q;

  // Code 11 is unreachable: the two compares are mutually exclusive.
  always_comb begin
    fb_d = 2'b00;
    if (a_msb < b_msb) begin
      fb_d = 2'b10;
    end else if (a_msb > b_msb) begin
      fb_d = 2'b01;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= EMPTY;
      valid_q    <= 1'b0;
      ready_q    <= 1'b1;
      a_lsb_q    <= '0;
      b_lsb_q    <= '0;
      fb_q       <= 2'b00;
      tag_q      <= '0;
      sk_a_lsb_q <= '0;
      sk_b_lsb_q <= '0;
      sk_fb_q    <= 2'b00;
      sk_tag_q   <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            a_lsb_q <= bus.A_i[HALF-1:0];
            b_lsb_q <= bus.B_i[HALF-1:0];
            fb_q    <= fb_d;
            tag_q   <= bus.tag_i;
            valid_q <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && bus.ready_i) begin
            // Old result consumed and new one loaded on the same edge.
            a_lsb_q <= bus.A_i[HALF-1:0];
            b_lsb_q <= bus.B_i[HALF-1:0];
            fb_q    <= fb_d;
            tag_q   <= bus.tag_i;
          end else if (in_xfer) begin
            // Downstream stalled: park the new pair, drop ready next cycle.
            sk_a_lsb_q <= bus.A_i[HALF-1:0];
            sk_b_lsb_q <= bus.B_i[HALF-1:0];
            sk_fb_q    <= fb_d;
            sk_tag_q   <= bus.tag_i;
            ready_q    <= 1'b0;
            state_q    <= FULL;
          end else if (bus.ready_i) begin
            valid_q <= 1'b0;
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (bus.ready_i) begin
            a_lsb_q <= sk_a_lsb_q;
            b_lsb_q <= sk_b_lsb_q;
            fb_q    <= sk_fb_q;
            tag_q   <= sk_tag_q;
            ready_q <= 1'b1;
            state_q <= BUSY;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_o    = ready_q;
  assign bus.valid_o    = valid_q;
  assign bus.A_lsb_o    = a_lsb_q;
  assign bus.B_lsb_o    = b_lsb_q;
  assign bus.feedback_o = fb_q;
  assign bus.tag_o      = tag_q;
endmodule
